// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage valid/dest/halt tracking, RAW stall, redirect flush, halt drain.
// Optional build macro PIPE_CTRL_FWD_EN restricts hazard checks to in-flight loads (results forwarded).
module pipe_ctrl #(
  parameter int STAGES     = 5,
  parameter int LOAD_STAGE = 3,
  parameter int RA_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic              id_rs_use,
  input  logic              id_rt_use,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              id_halt,
  input  logic              dec_err,
  input  logic              ex_redirect,
  output logic [STAGES-2:0] stage_valid,
  output logic              pc_en,
  output logic              stall,
  output logic              flush,
  output logic              halted,
  output logic              err
);

  // Highest stage whose destination can still cause a decode stall.
`ifdef PIPE_CTRL_FWD_EN
  localparam int WIN_HI = LOAD_STAGE - 1;
`else
  localparam int WIN_HI = STAGES - 2;
`endif

  logic                v1_q, v1_d;
  logic [STAGES-1:2]   v_q, v_d;
  logic [STAGES-1:2]   hlt_q, hlt_d;
  logic [WIN_HI:2]     wr_q, wr_d;
  logic [RA_W-1:0]     rd_q [2:WIN_HI];
  logic [RA_W-1:0]     rd_d [2:WIN_HI];
`ifdef PIPE_CTRL_FWD_EN
  logic [WIN_HI:2]     ld_q, ld_d;
`else
  logic                unused_load;
`endif
  logic                halt_pend_q, halt_pend_d;
  logic                err_q, err_d;
  logic                halted_q, halted_d;
  logic [WIN_HI:2]     match;
  logic                hazard;
  logic                dec_stop;
  logic                advance;

  genvar gi;

  generate
    for (gi = 2; gi <= WIN_HI; gi++) begin : g_match
`ifdef PIPE_CTRL_FWD_EN
      assign match[gi] = v_q[gi] & wr_q[gi] & ld_q[gi] &
                         (((rd_q[gi] == id_rs) & id_rs_use) | ((rd_q[gi] == id_rt) & id_rt_use));
`else
      assign match[gi] = v_q[gi] & wr_q[gi] &
                         (((rd_q[gi] == id_rs) & id_rs_use) | ((rd_q[gi] == id_rt) & id_rt_use));
`endif
    end
  endgenerate

`ifndef PIPE_CTRL_FWD_EN
  assign unused_load = id_load;
`endif

  assign hazard   = |match;
  assign flush    = v_q[2] & ex_redirect;
  assign stall    = v1_q & hazard & ~flush;
  assign dec_stop = v1_q & (id_halt | dec_err);
  // A redirect still steers fetch unless a halt is already draining.
  assign pc_en    = (flush & ~halt_pend_q) | (~stall & ~halt_pend_q & ~dec_stop);
  assign advance  = v1_q & ~stall & ~flush;

  assign v1_d     = stall ? v1_q : (if_valid & ~flush & ~halt_pend_q);
  assign v_d[2]   = advance;
  assign hlt_d[2] = id_halt | dec_err;
  assign wr_d[2]  = id_wr;
  assign rd_d[2]  = id_rd;
`ifdef PIPE_CTRL_FWD_EN
  assign ld_d[2]  = id_load;
`endif

  generate
    for (gi = 3; gi <= STAGES - 1; gi++) begin : g_shift
      assign v_d[gi]   = v_q[gi-1];
      assign hlt_d[gi] = hlt_q[gi-1];
    end
    for (gi = 3; gi <= WIN_HI; gi++) begin : g_shift_dst
      assign wr_d[gi] = wr_q[gi-1];
      assign rd_d[gi] = rd_q[gi-1];
`ifdef PIPE_CTRL_FWD_EN
      assign ld_d[gi] = ld_q[gi-1];
`endif
    end
  endgenerate

  assign halt_pend_d = halt_pend_q | (advance & (id_halt | dec_err));
  assign err_d       = err_q | (advance & dec_err);
  assign halted_d    = halted_q | (v_q[STAGES-1] & hlt_q[STAGES-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q        <= 1'b0;
      v_q         <= '0;
      hlt_q       <= '0;
      wr_q        <= '0;
      for (int k = 2; k <= WIN_HI; k++) begin
        rd_q[k] <= '0;
      end
`ifdef PIPE_CTRL_FWD_EN
      ld_q        <= '0;
`endif
      halt_pend_q <= 1'b0;
      err_q       <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      v_q         <= v_d;
      hlt_q       <= hlt_d;
      wr_q        <= wr_d;
      for (int k = 2; k <= WIN_HI; k++) begin
        rd_q[k] <= rd_d[k];
      end
`ifdef PIPE_CTRL_FWD_EN
      ld_q        <= ld_d;
`endif
      halt_pend_q <= halt_pend_d;
      err_q       <= err_d;
      halted_q    <= halted_d;
    end
  end

  assign stage_valid = {v_q, v1_q};
  assign err         = err_q;
  assign halted      = halted_q;

endmodule
